// File: rtl/ifetch_queue_pkg.sv
// Shared fetch-side definitions.
//   XLEN          : address / data width
//   ILEN          : instruction word width
//   fetch_entry_t : one instruction-queue entry {pc, instr}
package ifetch_queue_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_fifo.sv
// ifq_fifo: parameterised synchronous FIFO with a combinational head.
//   clk, rst  : clock, synchronous active-low reset (pointers/count only)
//   push, pop : enqueue din / drop head; both legal in the same cycle
//   clear     : empties the FIFO at the edge (wins over push/pop)
//   din       : data to enqueue
//   head      : current head entry (don't-care when count==0)
//   count     : number of stored entries, 0..DEPTH
// The caller never pushes when full (except alongside a pop) nor pops when empty.
module ifq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= next_ptr(wptr);
      if (pop)  rptr <= next_ptr(rptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; it is never reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  assign head = mem[rptr];

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: issues imem requests at the PC generator's address, collects
// in-order responses into an instruction queue and hands {pc, instr} to decode.
//   clk, rst            : clock, synchronous active-low reset
//   fetch_pc            : current PC from the PC generator
//   pc_reg_en           : advance the PC generator (request accepted)
//   imem_req_*          : request channel (valid/ready/word-aligned addr)
//   imem_rsp_valid/data : in-order responses, always accepted
//   flush               : redirect; empties the queue and drops stale responses
//   deq_*               : decode-side handshake and head entry
// The tag FIFO holds the PC of every live outstanding request, so its count
// is the live outstanding counter. Responses to requests issued before a
// flush are counted in drop_cnt and discarded as they arrive. The memory
// is assumed to hold at most MAX_OUT requests in flight in total.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pc_reg_en,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            flush,
  output logic            deq_valid,
  input  logic            deq_ready,
  output logic [XLEN-1:0] deq_pc,
  output logic [ILEN-1:0] deq_instr
);

  localparam int QW   = $clog2(DEPTH) + 1;
  localparam int OW   = $clog2(MAX_OUT) + 1;
  localparam int DMAX = (1 << OW) - 1;

  logic [QW-1:0]   q_count;
  logic [OW-1:0]   out_cnt;
  logic [OW-1:0]   drop_cnt;
  logic [XLEN-1:0] tag_head;
  fetch_entry_t    q_head;
  fetch_entry_t    q_din;
  logic            issue;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            deq_fire;

  // Stale responses still owed after a redirect, clamped to the counter range.
  function automatic logic [OW-1:0] drop_after_flush(input logic [OW-1:0] drop,
                                                     input logic [OW-1:0] outs,
                                                     input logic          rsp);
    int s;
    s = int'(drop) + int'(outs) - (rsp ? 1 : 0);
    if (s < 0)    s = 0;
    if (s > DMAX) s = DMAX;
    return OW'(s);
  endfunction

  // Credit check reserves a queue slot per outstanding request, so a
  // response always finds room.
  assign imem_req_valid = rst && !flush && (int'(out_cnt) < MAX_OUT) &&
                          ((int'(q_count) + int'(out_cnt)) < DEPTH);
  assign issue          = imem_req_valid && imem_req_ready;
  assign pc_reg_en      = issue;
  assign imem_req_addr  = {fetch_pc[XLEN-1:2], 2'b00};

  assign rsp_keep = rst && imem_rsp_valid && !flush && (drop_cnt == '0) && (out_cnt != '0);
  assign rsp_drop = rst && imem_rsp_valid && !flush && (drop_cnt != '0);

  assign deq_valid = rst && (q_count != '0) && !flush;
  assign deq_fire  = deq_valid && deq_ready;
  assign deq_pc    = q_head.pc;
  assign deq_instr = q_head.instr;

  assign q_din = '{pc: tag_head, instr: imem_rsp_data};

  ifq_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .pop   (rsp_keep),
    .clear (flush),
    .din   (fetch_pc),
    .head  (tag_head),
    .count (out_cnt)
  );

  ifq_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_q (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_keep),
    .pop   (deq_fire),
    .clear (flush),
    .din   (q_din),
    .head  (q_head),
    .count (q_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= drop_after_flush(drop_cnt, out_cnt, imem_rsp_valid);
    end else if (rsp_drop) begin
      drop_cnt <= drop_cnt - OW'(1);
    end
  end

  // A response with nothing outstanding and nothing to drop is a memory bug.
  a_rsp_tracked: assert property (@(posedge clk) disable iff (!rst)
    (imem_rsp_valid && !flush) |-> (out_cnt != '0 || drop_cnt != '0));

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised scoreboard bench for ifetch_queue. The reference tracks each
// request with the redirect epoch it was issued in: a response is delivered
// only if its epoch is still current and it does not land in a flush cycle.
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] fetch_pc;
  logic            pc_reg_en;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            flush;
  logic            deq_valid;
  logic            deq_ready;
  logic [XLEN-1:0] deq_pc;
  logic [ILEN-1:0] deq_instr;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_pc       (fetch_pc),
    .pc_reg_en      (pc_reg_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .flush          (flush),
    .deq_valid      (deq_valid),
    .deq_ready      (deq_ready),
    .deq_pc         (deq_pc),
    .deq_instr      (deq_instr)
  );

  typedef struct {
    logic [31:0] pc;
    int          ep;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  req_t        memq[$];
  ent_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          cur_ep = 0;
  int          live_out = 0;
  int          last_due = 0;
  int          issued = 0;
  logic [31:0] pcgen = '0;
  int          p_flush = 0;
  int          p_deq = 100;
  int          p_rdy = 100;
  int          lat_max = 1;
  logic        force_flush = 1'b0;
  logic [31:0] force_tgt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      32'h8:   return 32'h0020_0113;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0033;
    endcase
  endfunction

  task automatic one_cycle(input logic r);
    logic        do_flush;
    logic        exp_rv;
    logic        issue;
    logic [31:0] tgt;
    req_t        h;
    int          due;
    @(negedge clk);
    cyc++;
    rst      = r;
    do_flush = r && (force_flush || ($urandom_range(99) < p_flush));
    tgt      = force_flush ? force_tgt : $urandom;
    force_flush = 1'b0;
    flush     = do_flush;
    deq_ready = ($urandom_range(99) < p_deq);
    imem_req_ready = ($urandom_range(99) < p_rdy) && (memq.size() < MAX_OUT);
    if (r && memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(memq[0].pc);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    fetch_pc = pcgen;
    #1;
    exp_rv = r && !do_flush && (live_out < MAX_OUT) && ((expq.size() + live_out) < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    chk("pc_reg_en", 32'(pc_reg_en), 32'(exp_rv && imem_req_ready));
    if (exp_rv) chk("req_addr", imem_req_addr, {pcgen[31:2], 2'b00});
    if (pc_reg_en) issued++;
    issue = exp_rv && imem_req_ready;
    @(posedge clk);
    #1;
    if (!r) begin
      expq.delete();
      memq.delete();
      live_out = 0;
      last_due = cyc;
      cur_ep++;
    end else begin
      if (imem_rsp_valid) begin
        h = memq.pop_front();
        if (!do_flush && h.ep == cur_ep) begin
          expq.push_back('{pc: h.pc, instr: instr_of(h.pc)});
          live_out--;
        end
      end
      if (do_flush) begin
        expq.delete();
        cur_ep++;
        live_out = 0;
        pcgen = tgt;
      end else if (issue) begin
        due = cyc + int'($urandom_range(lat_max, 1));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        memq.push_back('{pc: pcgen, ep: cur_ep, due: due});
        live_out++;
        pcgen = pcgen + 32'd4;
      end
    end
  endtask

  // Monitor: compares the DUT's decode-side output against the scoreboard.
  ent_t mon_e;
  logic mon_dv;
  always @(negedge clk) begin
    #2;
    mon_dv = rst && (expq.size() != 0) && !flush;
    chk("deq_valid", 32'(deq_valid), 32'(mon_dv));
    if (deq_valid && deq_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deq_unexpected actual_pc=%h required=none", deq_pc);
      end else begin
        mon_e = expq.pop_front();
        chk("deq_pc", deq_pc, mon_e.pc);
        chk("deq_instr", deq_instr, mon_e.instr);
      end
    end
  end

  initial begin
    rst = 1'b0; flush = 1'b0; deq_ready = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; fetch_pc = '0;

    repeat (3) one_cycle(1'b0);

    // Streaming from pc 0 with a 1-cycle memory.
    p_flush = 0; p_deq = 100; p_rdy = 100; lat_max = 1;
    repeat (10) one_cycle(1'b1);

    // Backpressure: queue fills to DEPTH, then one pop frees one issue.
    repeat (2) one_cycle(1'b0);
    p_deq = 0; issued = 0;
    repeat (12) one_cycle(1'b1);
    chk("bp_issues", 32'(issued), 32'(DEPTH));
    p_deq = 100; issued = 0;
    one_cycle(1'b1);
    p_deq = 0;
    repeat (6) one_cycle(1'b1);
    chk("bp_one_more", 32'(issued), 32'd1);

    // Redirect to 0x100 with requests in flight.
    p_deq = 100; lat_max = 2;
    repeat (3) one_cycle(1'b1);
    force_flush = 1'b1; force_tgt = 32'h100;
    one_cycle(1'b1);
    repeat (10) one_cycle(1'b1);

    // Reset in the middle of traffic.
    p_deq = 30; lat_max = 3;
    repeat (6) one_cycle(1'b1);
    repeat (2) one_cycle(1'b0);
    repeat (6) one_cycle(1'b1);

    // Random traffic with redirects and occasional resets.
    p_flush = 6; p_deq = 70; p_rdy = 75; lat_max = 3;
    for (int i = 0; i < 3000; i++) one_cycle($urandom_range(999) >= 3);

    p_flush = 0; p_deq = 100;
    repeat (20) one_cycle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
